// File: rtl/gmii_pkg.sv
// Shared GMII transmit constants, FSM state encoding and the delay-line byte type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gmii_pkg;

  localparam logic [7:0]  GMII_PREAMBLE   = 8'h55;
  localparam logic [7:0]  GMII_SFD        = 8'hD5;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    DATA,
    PAD,
    FCS,
    IFG
  } tx_state_e;

  // One byte lane of the input stream: valid flag on top, data below,
  // matching the {valid, byte} layout of udp_i.
  typedef struct packed {
    logic       vld;
    logic [7:0] dat;
  } gmii_byte_t;

endpackage

// File: rtl/crc32_d8.sv
// Reflected CRC32 next-state for one byte (LSB-first bit order, Ethernet FCS).
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
module crc32_d8
  import gmii_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  // Eight shift/conditional-XOR steps unrolled; bit 0 of the byte goes in first.
  always_comb begin
    crc_next = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      crc_next = crc_next[0] ? ((crc_next >> 1) ^ CRC32_POLY_REFL) : (crc_next >> 1);
    end
  end

endmodule

// File: rtl/gmii_tx_framer.sv
// Wraps a raw byte stream into a GMII frame: preamble, SFD, data, zero pad, FCS, then IFG.
// Latency: first data byte leaves PREAMBLE_LEN+2 cycles after the input valid rise (9 by default).
// Backpressure: none; frames arriving while busy are discarded whole and counted.
module gmii_tx_framer
  import gmii_pkg::*;
#(
  parameter int MIN_FRAME    = 60,
  parameter int IFG_CYCLES   = 12,
  parameter int PREAMBLE_LEN = 7
) (
  input  logic        eth_rxck,
  input  logic        rst_rx,
  input  logic [8:0]  udp_i,
  output logic [7:0]  gmii_txd,
  output logic        gmii_txctl,
  output logic        busy_o,
  output logic [15:0] frame_cnt_o,
  output logic [15:0] drop_cnt_o
);

  // The delay line covers the preamble plus the SFD cycle, so the first
  // frame byte reaches the tap exactly when the FSM enters DATA.
  localparam int          DL_DEPTH = PREAMBLE_LEN + 1;
  localparam logic [10:0] MIN_LEN  = 11'(MIN_FRAME);
  localparam logic [10:0] BYTE_MAX = 11'd2047;
  localparam logic [3:0]  PRE_LAST = 4'(PREAMBLE_LEN);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_CYCLES - 1);

  gmii_byte_t  dline [DL_DEPTH];
  gmii_byte_t  tap;
  tx_state_e   state;
  logic        in_vld_q;
  logic        vld_rise;
  logic        drop_flag;
  logic        drop_hit;
  logic        start_ok;
  logic [3:0]  pre_cnt;
  logic [10:0] byte_cnt;
  logic [1:0]  fcs_idx;
  logic [7:0]  ifg_cnt;
  logic [31:0] crc;
  logic [31:0] crc_next;
  logic [7:0]  crc_byte;
  logic [7:0]  fcs_byte;

  assign vld_rise = udp_i[8] & ~in_vld_q;
  assign drop_hit = vld_rise & (state != IDLE);
  assign start_ok = vld_rise & ~drop_flag & (state == IDLE);
  assign tap      = dline[DL_DEPTH-1];
  // Padding shares the CRC engine with data; pad bytes are simply zero.
  assign crc_byte = (state == DATA && tap.vld) ? tap.dat : 8'h00;
  assign fcs_byte = ~crc[{fcs_idx, 3'b000} +: 8];

  crc32_d8 u_crc (
    .crc      (crc),
    .data     (crc_byte),
    .crc_next (crc_next)
  );

  // Delay line: holds input bytes back until the preamble and SFD are out; a dropped run is blanked.
  always_ff @(posedge eth_rxck) begin
    if (rst_rx) begin
      for (int i = 0; i < DL_DEPTH; i++) dline[i] <= '0;
      in_vld_q <= 1'b0;
    end else begin
      dline[0] <= (drop_flag || drop_hit) ? '0 : gmii_byte_t'(udp_i);
      for (int i = 1; i < DL_DEPTH; i++) dline[i] <= dline[i-1];
      in_vld_q <= udp_i[8];
    end
  end

  // Drop tracking: a run that starts while busy is ignored until its valid drops, counted once.
  always_ff @(posedge eth_rxck) begin
    if (rst_rx) begin
      drop_flag  <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      if (!udp_i[8])     drop_flag <= 1'b0;
      else if (drop_hit) drop_flag <= 1'b1;
      if (drop_hit) drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end

  // Transmit FSM: every GMII output is registered here, one byte decided per edge.
  always_ff @(posedge eth_rxck) begin
    if (rst_rx) begin
      state       <= IDLE;
      gmii_txd    <= '0;
      gmii_txctl  <= 1'b0;
      busy_o      <= 1'b0;
      frame_cnt_o <= '0;
      crc         <= CRC32_INIT;
      pre_cnt     <= '0;
      byte_cnt    <= '0;
      fcs_idx     <= '0;
      ifg_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          gmii_txd   <= '0;
          gmii_txctl <= 1'b0;
          if (start_ok) begin
            state      <= PRE;
            gmii_txd   <= GMII_PREAMBLE;
            gmii_txctl <= 1'b1;
            busy_o     <= 1'b1;
            crc        <= CRC32_INIT;
            pre_cnt    <= 4'd1;
            byte_cnt   <= '0;
          end
        end
        PRE: begin
          if (pre_cnt == PRE_LAST) begin
            gmii_txd <= GMII_SFD;
            state    <= DATA;
          end else begin
            gmii_txd <= GMII_PREAMBLE;
            pre_cnt  <= pre_cnt + 4'd1;
          end
        end
        DATA: begin
          if (tap.vld) begin
            gmii_txd <= tap.dat;
            crc      <= crc_next;
            if (byte_cnt != BYTE_MAX) byte_cnt <= byte_cnt + 11'd1;
          end else if (byte_cnt < MIN_LEN) begin
            // First pad byte goes out on the same edge so TX_EN never gaps.
            gmii_txd <= 8'h00;
            crc      <= crc_next;
            byte_cnt <= byte_cnt + 11'd1;
            fcs_idx  <= 2'd0;
            state    <= (byte_cnt + 11'd1 == MIN_LEN) ? FCS : PAD;
          end else begin
            // CRC is already final; emit FCS byte 0 now and continue from byte 1.
            gmii_txd <= fcs_byte;
            fcs_idx  <= 2'd1;
            state    <= FCS;
          end
        end
        PAD: begin
          gmii_txd <= 8'h00;
          crc      <= crc_next;
          byte_cnt <= byte_cnt + 11'd1;
          if (byte_cnt + 11'd1 == MIN_LEN) begin
            fcs_idx <= 2'd0;
            state   <= FCS;
          end
        end
        FCS: begin
          gmii_txd <= fcs_byte;
          fcs_idx  <= fcs_idx + 2'd1;
          if (fcs_idx == 2'd3) begin
            state       <= IFG;
            frame_cnt_o <= frame_cnt_o + 16'd1;
            ifg_cnt     <= '0;
          end
        end
        IFG: begin
          gmii_txd   <= '0;
          gmii_txctl <= 1'b0;
          if (ifg_cnt == IFG_LAST) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            ifg_cnt <= ifg_cnt + 8'd1;
          end
        end
        default: begin
          state      <= IDLE;
          gmii_txd   <= '0;
          gmii_txctl <= 1'b0;
          busy_o     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Bench for gmii_tx_framer: randomized frames scored against a frame-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_gmii_tx_framer;

  localparam int IFG  = 12;
  localparam int MINF = 60;

  typedef byte unsigned bq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  udp, udp0;
  logic [7:0]  txd, txd0;
  logic        txctl, txctl0, busy, busy0;
  logic [15:0] fcnt, dcnt, fcnt0, dcnt0;

  always #4 clk = ~clk;

  gmii_tx_framer dut (
    .eth_rxck(clk), .rst_rx(rst), .udp_i(udp), .gmii_txd(txd), .gmii_txctl(txctl),
    .busy_o(busy), .frame_cnt_o(fcnt), .drop_cnt_o(dcnt)
  );

  gmii_tx_framer #(.MIN_FRAME(0)) dut0 (
    .eth_rxck(clk), .rst_rx(rst), .udp_i(udp0), .gmii_txd(txd0), .gmii_txctl(txctl0),
    .busy_o(busy0), .frame_cnt_o(fcnt0), .drop_cnt_o(dcnt0)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Captured wire traffic: bytes while TX_EN is high, plus per-frame length and first cycle.
  byte unsigned rx_q[$], rx0_q[$], exp_q[$];
  int rx_len[$], rx_start[$], rx0_len[$], exp_len[$], exp_start[$];
  int cur_len = 0, cur0_len = 0;

  always @(negedge clk) begin
    if (txctl) begin
      if (cur_len == 0) rx_start.push_back(cyc);
      rx_q.push_back(txd);
      cur_len++;
    end else if (cur_len != 0) begin
      rx_len.push_back(cur_len);
      cur_len = 0;
    end
    if (txctl0) begin
      rx0_q.push_back(txd0);
      cur0_len++;
    end else if (cur0_len != 0) begin
      rx0_len.push_back(cur0_len);
      cur0_len = 0;
    end
  end

  // Reference model: a frame is accepted iff it starts once the previous
  // accepted frame's wire time plus the gap has elapsed.
  int free_at  = 0;
  int m_frames = 0;
  int m_drops  = 0;

  // Bit-serial CRC32 (LSB first), returned already complemented.
  function automatic logic [31:0] ref_fcs(input bq_t b);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ b[i][k];
        c  = {1'b0, c[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
      end
    end
    return ~c;
  endfunction

  function automatic bq_t rand_bytes(input int n);
    bq_t q;
    for (int k = 0; k < n; k++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic flush();
    rx_q.delete(); rx_len.delete(); rx_start.delete();
    exp_q.delete(); exp_len.delete(); exp_start.delete();
  endtask

  task automatic wait_done();
    while (cyc < free_at + 3) idle(1);
  endtask

  // Drive one valid run starting now; the model decides accept/drop and appends the expected wire bytes.
  task automatic send(input bq_t d);
    bq_t         f;
    logic [31:0] c;
    int          t0;
    t0 = cyc;
    if (t0 >= free_at) begin
      f = d;
      while (f.size() < MINF) f.push_back(8'h00);
      c = ref_fcs(f);
      for (int k = 0; k < 4; k++) f.push_back(c[8*k +: 8]);
      for (int k = 0; k < 7; k++) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
      foreach (f[k]) exp_q.push_back(f[k]);
      exp_len.push_back(f.size() + 8);
      exp_start.push_back(t0 + 1);
      free_at = t0 + f.size() + 8 + IFG;
      m_frames++;
    end else begin
      m_drops++;
    end
    foreach (d[k]) begin
      udp = {1'b1, d[k]};
      idle(1);
    end
    udp = 9'h000;
    idle(1);
  endtask

  task automatic test_reset();
    rst = 1'b1; udp = '0; udp0 = '0;
    idle(3);
    total++;
    if ({txd, txctl, busy, fcnt, dcnt} !== 42'd0) begin
      bad++; $display("FAIL reset_state got txd=%h en=%b busy=%b fc=%0d dc=%0d want all 0", txd, txctl, busy, fcnt, dcnt);
    end
    total++;
    if ({txd0, txctl0, busy0, fcnt0, dcnt0} !== 42'd0) begin
      bad++; $display("FAIL reset_state_nopad got txd=%h en=%b busy=%b fc=%0d dc=%0d want all 0", txd0, txctl0, busy0, fcnt0, dcnt0);
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_crc_vector();
    bq_t want;
    int  nerr;
    for (int k = 0; k < 7; k++) want.push_back(8'h55);
    want.push_back(8'hD5);
    for (int k = 0; k < 9; k++) want.push_back(8'(8'h31 + k));
    want.push_back(8'h26); want.push_back(8'h39); want.push_back(8'hF4); want.push_back(8'hCB);
    rx0_q.delete(); rx0_len.delete();
    for (int k = 0; k < 9; k++) begin
      udp0 = {1'b1, 8'(8'h31 + k)};
      idle(1);
    end
    udp0 = '0;
    idle(40);
    total++;
    if (rx0_len.size() != 1 || rx0_len[0] != 21) begin
      bad++; $display("FAIL crc_vec_txen frames=%0d len=%0d want 1 frame of 21", rx0_len.size(), (rx0_len.size() > 0) ? rx0_len[0] : 0);
    end
    nerr = 0;
    foreach (want[i]) if (i >= rx0_q.size() || rx0_q[i] !== want[i]) nerr++;
    total++;
    if (nerr != 0) begin bad++; $display("FAIL crc_vec_bytes wrong=%0d of %0d", nerr, want.size()); end
    total++;
    if (fcnt0 !== 16'd1 || dcnt0 !== 16'd0) begin
      bad++; $display("FAIL crc_vec_counters got fc=%0d dc=%0d want 1 0", fcnt0, dcnt0);
    end
  endtask

  task automatic test_padding();
    int t0, nerr;
    flush();
    t0 = cyc;
    send(rand_bytes(10));
    wait_done();
    total++;
    if (rx_len.size() != 1 || rx_len[0] != 72) begin
      bad++; $display("FAIL pad_txen frames=%0d len=%0d want 1 frame of 72", rx_len.size(), (rx_len.size() > 0) ? rx_len[0] : 0);
    end
    total++;
    if (rx_start.size() < 1 || rx_start[0] + 8 != t0 + 9) begin
      bad++; $display("FAIL pad_latency first data at %0d want %0d", (rx_start.size() > 0) ? rx_start[0] + 8 : -1, t0 + 9);
    end
    nerr = 0;
    for (int i = 18; i < 68; i++) if (i >= rx_q.size() || rx_q[i] !== 8'h00) nerr++;
    total++;
    if (nerr != 0) begin bad++; $display("FAIL pad_zeros nonzero=%0d want 0", nerr); end
    nerr = 0;
    foreach (exp_q[i]) if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) nerr++;
    total++;
    if (nerr != 0) begin bad++; $display("FAIL pad_bytes wrong=%0d of %0d", nerr, exp_q.size()); end
    total++;
    if (fcnt !== 16'(m_frames)) begin bad++; $display("FAIL pad_fcnt got=%0d want=%0d", fcnt, m_frames); end
  endtask

  task automatic test_back_to_back();
    int nerr;
    flush();
    send(rand_bytes(60));
    while (cyc < free_at - IFG + 20) idle(1);
    send(rand_bytes(60));
    wait_done();
    total++;
    if (rx_len.size() != 2) begin bad++; $display("FAIL b2b_frames got=%0d want=2", rx_len.size()); end
    for (int i = 0; i < exp_len.size() && i < rx_len.size(); i++) begin
      total++;
      if (rx_len[i] !== exp_len[i] || rx_start[i] !== exp_start[i]) begin
        bad++; $display("FAIL b2b_frame%0d len=%0d start=%0d want len=%0d start=%0d", i, rx_len[i], rx_start[i], exp_len[i], exp_start[i]);
      end
    end
    total++;
    if (rx_len.size() >= 2 && rx_start[1] - (rx_start[0] + rx_len[0]) < IFG) begin
      bad++; $display("FAIL b2b_gap got=%0d want>=%0d", rx_start[1] - (rx_start[0] + rx_len[0]), IFG);
    end
    nerr = 0;
    foreach (exp_q[i]) if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) nerr++;
    total++;
    if (nerr != 0) begin bad++; $display("FAIL b2b_bytes wrong=%0d of %0d", nerr, exp_q.size()); end
    total++;
    if (dcnt !== 16'(m_drops) || fcnt !== 16'(m_frames)) begin
      bad++; $display("FAIL b2b_counters got fc=%0d dc=%0d want fc=%0d dc=%0d", fcnt, dcnt, m_frames, m_drops);
    end
  endtask

  task automatic test_drop();
    int nerr;
    flush();
    send(rand_bytes(60));
    idle(2);
    send(rand_bytes(8));          // starts while the first frame is still going out
    while (cyc < free_at - 1) idle(1);
    send(rand_bytes(5));          // starts on the last IFG cycle
    send(rand_bytes(30));         // back in IDLE by now
    while (cyc < free_at) idle(1);
    send(rand_bytes(12));         // starts on the very first IDLE cycle
    wait_done();
    total++;
    if (rx_len.size() != exp_len.size()) begin
      bad++; $display("FAIL drop_frames got=%0d want=%0d", rx_len.size(), exp_len.size());
    end
    for (int i = 0; i < exp_len.size() && i < rx_len.size(); i++) begin
      total++;
      if (rx_len[i] !== exp_len[i] || rx_start[i] !== exp_start[i]) begin
        bad++; $display("FAIL drop_frame%0d len=%0d start=%0d want len=%0d start=%0d", i, rx_len[i], rx_start[i], exp_len[i], exp_start[i]);
      end
    end
    nerr = 0;
    foreach (exp_q[i]) if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) nerr++;
    total++;
    if (nerr != 0) begin bad++; $display("FAIL drop_bytes wrong=%0d of %0d", nerr, exp_q.size()); end
    total++;
    if (dcnt !== 16'(m_drops) || fcnt !== 16'(m_frames)) begin
      bad++; $display("FAIL drop_counters got fc=%0d dc=%0d want fc=%0d dc=%0d", fcnt, dcnt, m_frames, m_drops);
    end
  endtask

  task automatic test_reset_midframe();
    bq_t d;
    int  t0, nerr;
    flush();
    d  = rand_bytes(24);
    t0 = cyc;
    send(d);
    while (cyc < t0 + 29) idle(1);
    total++;
    if (txctl !== 1'b1 || txd !== d[20]) begin
      bad++; $display("FAIL rstmid_byte20 got en=%b txd=%h want en=1 txd=%h", txctl, txd, d[20]);
    end
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    total++;
    if (txctl !== 1'b0 || busy !== 1'b0 || fcnt !== 16'd0 || dcnt !== 16'd0) begin
      bad++; $display("FAIL rstmid_state got en=%b busy=%b fc=%0d dc=%0d want 0 0 0 0", txctl, busy, fcnt, dcnt);
    end
    free_at = 0; m_frames = 0; m_drops = 0;
    idle(2);
    flush();
    send(rand_bytes(40));
    wait_done();
    total++;
    if (rx_len.size() != 1 || rx_len[0] !== exp_len[0] || rx_start[0] !== exp_start[0]) begin
      bad++; $display("FAIL rstmid_after frames=%0d want 1 of len %0d at %0d", rx_len.size(), exp_len[0], exp_start[0]);
    end
    nerr = 0;
    foreach (exp_q[i]) if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) nerr++;
    total++;
    if (nerr != 0 || fcnt !== 16'd1) begin
      bad++; $display("FAIL rstmid_bytes wrong=%0d fc=%0d want 0 wrong fc=1", nerr, fcnt);
    end
  endtask

  task automatic test_oversize();
    int nerr;
    flush();
    send(rand_bytes(1600));
    while (cyc < free_at - 1) idle(1);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL big_busy_ifg got=%b want=1", busy); end
    idle(1);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL big_busy_idle got=%b want=0", busy); end
    wait_done();
    total++;
    if (rx_len.size() != 1 || rx_len[0] != 1612) begin
      bad++; $display("FAIL big_len frames=%0d len=%0d want 1 frame of 1612", rx_len.size(), (rx_len.size() > 0) ? rx_len[0] : 0);
    end
    nerr = 0;
    foreach (exp_q[i]) if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) nerr++;
    total++;
    if (nerr != 0) begin bad++; $display("FAIL big_bytes wrong=%0d of %0d", nerr, exp_q.size()); end
  endtask

  task automatic test_random();
    int nerr;
    flush();
    for (int n = 0; n < 10; n++) begin
      send(rand_bytes($urandom_range(1, 100)));
      idle($urandom_range(0, 90));
    end
    wait_done();
    total++;
    if (rx_len.size() != exp_len.size()) begin
      bad++; $display("FAIL rand_frames got=%0d want=%0d", rx_len.size(), exp_len.size());
    end
    for (int i = 0; i < exp_len.size() && i < rx_len.size(); i++) begin
      total++;
      if (rx_len[i] !== exp_len[i] || rx_start[i] !== exp_start[i]) begin
        bad++; $display("FAIL rand_frame%0d len=%0d start=%0d want len=%0d start=%0d", i, rx_len[i], rx_start[i], exp_len[i], exp_start[i]);
      end
    end
    nerr = 0;
    foreach (exp_q[i]) if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) nerr++;
    total++;
    if (nerr != 0) begin bad++; $display("FAIL rand_bytes wrong=%0d of %0d", nerr, exp_q.size()); end
    total++;
    if (dcnt !== 16'(m_drops) || fcnt !== 16'(m_frames)) begin
      bad++; $display("FAIL rand_counters got fc=%0d dc=%0d want fc=%0d dc=%0d", fcnt, dcnt, m_frames, m_drops);
    end
  endtask

  initial begin
    test_reset();
    test_crc_vector();
    test_padding();
    test_back_to_back();
    test_drop();
    test_oversize();
    test_reset_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
